// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - ALU control codes, FSM state encoding and helpers shared by the muldiv unit.
package muldiv_unit_pkg;

  localparam logic [4:0] ADD_CONTROL   = 5'b00010;
  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Magnitude of a two's-complement operand; unsigned ops pass through untouched.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// rtl/muldiv_unit_div_radix2.sv - One restoring radix-2 divide step: shift in a dividend bit, trial subtract, shift out a quotient bit.
module div_radix2 (
  input  logic [32:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quot_o
);

  logic [33:0] diff;
  logic        ge;

  always_comb begin
    diff   = {rem_i, quot_i[31]} - {2'b00, divisor_i};
    ge     = ~diff[33];
    rem_o  = ge ? diff[32:0] : {rem_i[31:0], quot_i[31]};
    quot_o = {quot_i[30:0], ge};
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
// MULDIV_FAST_MUL_EN selects a single-cycle array multiply instead of 32-step shift-add.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] work_hi_q, work_hi_d;
  logic [31:0] work_lo_q, work_lo_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_q, neg_d, neg_rem_q, neg_rem_d, b_zero_q, b_zero_d;

  logic        is_mul_op, is_div_op, is_signed, accept;
  logic [31:0] mag_a, mag_b;
  logic [32:0] div_rem;
  logic [31:0] div_quot, quot_fix, rem_fix;
  logic [63:0] prod, mul_res;
`ifndef MULDIV_FAST_MUL_EN
  logic [32:0] sum;
`endif

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Divide: work_hi = partial remainder, work_lo = dividend shifting out / quotient shifting in.
  div_radix2 u_div (
    .rem_i     (work_hi_q),
    .quot_i    (work_lo_q),
    .divisor_i (operand_q),
    .rem_o     (div_rem),
    .quot_o    (div_quot)
  );

  always_comb begin
    is_mul_op = (alu_control == MULT_CONTROL) || (alu_control == MULTU_CONTROL);
    is_div_op = (alu_control == DIV_CONTROL)  || (alu_control == DIVU_CONTROL);
    is_signed = (alu_control == MULT_CONTROL) || (alu_control == DIV_CONTROL);
    accept    = start && !flush && (is_mul_op || is_div_op) &&
                ((state_q == ST_IDLE) || (state_q == ST_DONE));
    mag_a     = abs_if(a, is_signed);
    mag_b     = abs_if(b, is_signed);
  end

  // Multiply: operand = multiplicand, {work_hi, work_lo} = accumulator with multiplier in the low half.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = 64'(operand_q) * 64'(work_lo_q);
`else
    sum  = {1'b0, work_hi_q[31:0]} + {1'b0, (work_lo_q[0] ? operand_q : 32'd0)};
    prod = {sum, work_lo_q[31:1]};
`endif
    mul_res  = neg_q ? -prod : prod;
    quot_fix = b_zero_q ? 32'hFFFF_FFFF : (neg_q ? -div_quot : div_quot);
    rem_fix  = neg_rem_q ? -div_rem[31:0] : div_rem[31:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d   = is_mul_op ? ST_MUL : ST_DIV;
          cnt_d     = 6'd0;
          work_hi_d = 33'd0;
          work_lo_d = is_mul_op ? mag_b : mag_a;
          operand_d = is_mul_op ? mag_a : mag_b;
          neg_d     = is_signed && (a[31] ^ b[31]);
          neg_rem_d = is_signed && a[31];
          b_zero_d  = (b == 32'd0);
        end
      end
      ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        hi_d    = mul_res[63:32];
        lo_d    = mul_res[31:0];
        state_d = ST_DONE;
`else
        work_hi_d = {1'b0, sum[32:1]};
        work_lo_d = {sum[0], work_lo_q[31:1]};
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
          state_d = ST_DONE;
        end
`endif
      end
      ST_DIV: begin
        work_hi_d = div_rem;
        work_lo_d = div_quot;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          hi_d    = rem_fix;
          lo_d    = quot_fix;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush beats everything, including a same-cycle start or a final iteration.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      work_hi_q <= 33'd0;
      work_lo_q <= 32'd0;
      operand_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Directed vector bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int NVEC    = 13;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alu_control;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  vec_t vecs[NVEC];

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op and count negedges until done; lat==1 is the first cycle after accept.
  task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit no_wait, output int lat, output logic busy_first);
    if (!no_wait) @(negedge clk);
    start = 1'b1; alu_control = op; a = av; b = bv;
    lat = 0;
    busy_first = 1'b0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) busy_first = busy;
    end while (!done && lat < 100);
  endtask

  initial begin
    int          lat;
    logic        bf;
    logic        saw_done;
    logic [31:0] prev_hi, prev_lo;

    vecs[0]  = '{MULT_CONTROL,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{DIV_CONTROL,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{DIVU_CONTROL,  32'd7,         32'd2,         32'd1,         32'd3};
    vecs[4]  = '{DIV_CONTROL,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{DIVU_CONTROL,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[6]  = '{MULT_CONTROL,  32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd0,         32'd21};
    vecs[7]  = '{MULTU_CONTROL, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780};
    vecs[8]  = '{DIV_CONTROL,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{DIV_CONTROL,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{DIVU_CONTROL,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF};
    vecs[11] = '{MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[12] = '{DIV_CONTROL,   32'd100,       32'd7,         32'd2,         32'd14};

    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_control = 5'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      bit is_mul;
      is_mul = (vecs[i].op == MULT_CONTROL) || (vecs[i].op == MULTU_CONTROL);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bf);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(is_mul ? MUL_LAT : DIV_LAT));
      check($sformatf("v%0d busy", i), 64'(bf), 64'd1);
      check($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // Non-muldiv code is ignored.
    @(negedge clk);
    start = 1'b1; alu_control = ADD_CONTROL; a = 32'd1; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("add busy", 64'(busy), 64'd0);
    check("add done", 64'(done), 64'd0);
    check("add hi", 64'(hi), 64'd2);
    check("add lo", 64'(lo), 64'd14);

    // Start during MUL is ignored.
    @(negedge clk);
    start = 1'b1; alu_control = MULT_CONTROL; a = 32'd3; b = 32'd5;
    @(negedge clk);
    lat = 1;
    check("mulstart busy", 64'(busy), 64'd1);
    alu_control = DIVU_CONTROL; a = 32'd100; b = 32'd3;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 100);
    check("mulstart latency", 64'(lat), 64'(MUL_LAT));
    check("mulstart hi", 64'(hi), 64'd0);
    check("mulstart lo", 64'(lo), 64'd15);
    @(negedge clk);
    check("mulstart no div", 64'(busy), 64'd0);

    // Back-to-back: second op accepted in the first op's DONE cycle.
    run_op(DIVU_CONTROL, 32'd7, 32'd2, 1'b0, lat, bf);
    check("b2b first latency", 64'(lat), 64'(DIV_LAT));
    check("b2b first lo", 64'(lo), 64'd3);
    check("b2b first hi", 64'(hi), 64'd1);
    run_op(MULTU_CONTROL, 32'd6, 32'd7, 1'b1, lat, bf);
    check("b2b second busy", 64'(bf), 64'd1);
    check("b2b second latency", 64'(lat), 64'(MUL_LAT));
    check("b2b second lo", 64'(lo), 64'd42);
    check("b2b second hi", 64'(hi), 64'd0);

    // Flush at N+10.
    prev_hi = 32'd0; prev_lo = 32'd42;
    @(negedge clk);
    start = 1'b1; alu_control = DIVU_CONTROL; a = 32'd100; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    saw_done = done;
    repeat (40) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("flush no done", 64'(saw_done), 64'd0);
    check("flush hi", 64'(hi), 64'(prev_hi));
    check("flush lo", 64'(lo), 64'(prev_lo));

    // Reset at N+10.
    @(negedge clk);
    start = 1'b1; alu_control = DIVU_CONTROL; a = 32'd100; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", 64'(busy), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    saw_done = done;
    repeat (40) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("rst no done", 64'(saw_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
